// File: rtl/reg80_byte_reader_pkg.sv
// Shared constants, state encoding and word view for the 80-bit register byte reader.
package reg80_byte_reader_pkg;

  localparam int NBYTES = 10;
  localparam int BYTE_W = 8;
  localparam int WORD_W = NBYTES * BYTE_W;
  localparam int IDX_W  = 4;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Byte lane 0 is bits [7:0], matching the register bank lane order.
  typedef logic [NBYTES-1:0][BYTE_W-1:0] word_t;

  function automatic logic [BYTE_W-1:0] select_byte(input word_t w, input logic [IDX_W-1:0] i);
    return w[i];
  endfunction

endpackage

// File: rtl/reg80_byte_reader_if.sv
// Byte-stream side of the reader: valid/ready byte lane plus LAST/DONE markers.
interface reg80_byte_reader_if;

  logic [reg80_byte_reader_pkg::BYTE_W-1:0] byte_out;
  logic                                     byte_valid;
  logic                                     byte_ready;
  logic                                     LAST;
  logic                                     DONE;

  modport master (
    output byte_out,
    output byte_valid,
    output LAST,
    output DONE,
    input  byte_ready
  );

  modport slave (
    input  byte_out,
    input  byte_valid,
    input  LAST,
    input  DONE,
    output byte_ready
  );

endinterface

// File: rtl/reg80_byte_reader_snapshot.sv
// 80-bit load-enabled holding register assembled from 8-bit register cells.
module reg8_cell (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] d,
  output logic [7:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 8'h00;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

module reg80_snapshot
  import reg80_byte_reader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WORD_W-1:0] d,
  output word_t             q
);

  word_t d_lanes;
  assign d_lanes = d;

  for (genvar b = 0; b < NBYTES; b++) begin : g_cell
    reg8_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (load),
      .d     (d_lanes[b]),
      .q     (q[b])
    );
  end

endmodule

// File: rtl/reg80_byte_reader.sv
// Snapshots an 80-bit word on START and streams it LSB-first as bytes over a valid/ready lane.
module reg80_byte_reader
  import reg80_byte_reader_pkg::*;
(
  input  logic                CLK,
  input  logic                RESET,
  input  logic                START,
  input  logic [WORD_W-1:0]   reg_in,
  output logic                BUSY,
  reg80_byte_reader_if.master bus
);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_next;
  word_t            snap;
  logic             load;

  assign load     = (state == IDLE) && START;
  assign idx_next = idx + IDX_W'(1);

  reg80_snapshot u_snapshot (
    .clk   (CLK),
    .rst_n (RESET),
    .load  (load),
    .d     (reg_in),
    .q     (snap)
  );

  // Byte 0 comes straight from reg_in because the snapshot loads on the same edge.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state          <= IDLE;
      idx            <= '0;
      BUSY           <= 1'b0;
      bus.byte_valid <= 1'b0;
      bus.byte_out   <= '0;
      bus.LAST       <= 1'b0;
      bus.DONE       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.DONE <= 1'b0;
          if (START) begin
            state          <= SEND;
            idx            <= '0;
            BUSY           <= 1'b1;
            bus.byte_valid <= 1'b1;
            bus.byte_out   <= reg_in[BYTE_W-1:0];
            bus.LAST       <= (LAST_IDX == '0);
          end
        end
        SEND: begin
          if (bus.byte_ready) begin
            if (idx != LAST_IDX) begin
              idx          <= idx_next;
              bus.byte_out <= select_byte(snap, idx_next);
              bus.LAST     <= (idx_next == LAST_IDX);
            end else begin
              state          <= FINISH;
              BUSY           <= 1'b0;
              bus.byte_valid <= 1'b0;
              bus.byte_out   <= '0;
              bus.LAST       <= 1'b0;
              bus.DONE       <= 1'b1;
            end
          end
        end
        FINISH: begin
          bus.DONE <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg80_byte_reader.sv
// Scoreboard bench for reg80_byte_reader: stimulus queues expected bytes/DONE cycles, a monitor checks them.
module tb_reg80_byte_reader;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         cyc;
  } exp_t;

  logic        CLK;
  logic        RESET;
  logic        START;
  logic [79:0] reg_in;
  logic        BUSY;

  reg80_byte_reader_if bus ();

  reg80_byte_reader dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .START  (START),
    .reg_in (reg_in),
    .BUSY   (BUSY),
    .bus    (bus)
  );

  localparam logic [79:0] WORD_A = 80'h0123_4567_89AB_CDEF_0011;
  localparam logic [79:0] WORD_B = 80'hFEDC_BA98_7654_3210_0FF0;

  logic [7:0] bytesA [10] = '{8'h11, 8'h00, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
  logic [7:0] bytesB [10] = '{8'hF0, 8'h0F, 8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hBA, 8'hDC, 8'hFE};

  exp_t expQ [$];
  int   doneQ [$];
  int   edgeCount = 0;
  int   base = 0;
  int   errors = 0;
  int   checks = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) edgeCount <= edgeCount + 1;

  task automatic checkOutput(input string name, input logic [79:0] actual, input logic [79:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Bytes after position stallAfter are delayed by stallLen cycles of backpressure.
  task automatic pushSeq(input logic [7:0] b [10], input int n, input int firstCyc,
                         input int stallAfter, input int stallLen, input int doneCyc);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.data = b[i];
      e.last = (i == 9);
      e.cyc  = firstCyc + i + ((i >= stallAfter) ? stallLen : 0);
      expQ.push_back(e);
    end
    if (doneCyc > 0) doneQ.push_back(doneCyc);
  endtask

  // Cycle 0 carries START; inputs for cycle k are set just after the edge that opens it.
  task automatic applyStimulus(input logic [79:0] word, input int nCycles,
                               input int stallLo, input int stallHi, input int reStart,
                               input bit holdStart, input int flipAt, input logic [79:0] flipWord,
                               input int busyEnd, input logic [7:0] holdByte);
    @(posedge CLK); #1;
    base       = edgeCount;
    START      = 1'b1;
    reg_in     = word;
    bus.byte_ready = 1'b1;
    for (int k = 1; k <= nCycles; k++) begin
      @(posedge CLK); #1;
      START = holdStart || (k == reStart);
      if (k == flipAt) reg_in = flipWord;
      bus.byte_ready = !(k >= stallLo && k <= stallHi);
      #2;
      if (busyEnd > 0) checkOutput($sformatf("busy_c%0d", k), BUSY, (k <= busyEnd));
      if (k >= stallLo && k <= stallHi) begin
        checkOutput($sformatf("stall_byte_c%0d", k), bus.byte_out, holdByte);
        checkOutput($sformatf("stall_valid_c%0d", k), bus.byte_valid, 1'b1);
      end
    end
    START = 1'b0;
    bus.byte_ready = 1'b1;
  endtask

  task automatic drainCheck(input string tag);
    repeat (4) @(posedge CLK);
    #3;
    checkOutput({tag, "_bytes_left"}, expQ.size(), 0);
    checkOutput({tag, "_done_left"}, doneQ.size(), 0);
    expQ.delete();
    doneQ.delete();
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_byte_out"}, bus.byte_out, 8'h00);
    checkOutput({tag, "_valid"}, bus.byte_valid, 1'b0);
    checkOutput({tag, "_busy"}, BUSY, 1'b0);
    checkOutput({tag, "_last"}, bus.LAST, 1'b0);
    checkOutput({tag, "_done"}, bus.DONE, 1'b0);
  endtask

  always @(negedge CLK) begin : monitor
    exp_t e;
    int   d;
    if (RESET) begin
      if (bus.byte_valid && bus.byte_ready) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_byte: got %0h, required no transfer", bus.byte_out);
        end else begin
          e = expQ.pop_front();
          checkOutput("xfer_data", bus.byte_out, e.data);
          checkOutput("xfer_last", bus.LAST, e.last);
          checkOutput("xfer_cycle", edgeCount - base, e.cyc);
        end
      end else if (bus.byte_valid == 1'b0) begin
        checkOutput("last_without_valid", bus.LAST, 1'b0);
      end
      if (bus.DONE) begin
        if (doneQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done: got pulse at cycle %0d, required none", edgeCount - base);
        end else begin
          d = doneQ.pop_front();
          checkOutput("done_cycle", edgeCount - base, d);
          checkOutput("done_busy", BUSY, 1'b0);
          checkOutput("done_valid", bus.byte_valid, 1'b0);
        end
      end
    end
  end

  initial begin
    RESET          = 1'b0;
    START          = 1'($urandom);
    reg_in         = {$urandom, $urandom, 16'($urandom)};
    bus.byte_ready = 1'($urandom);
    #13;
    checkIdleOutputs("reset");

    @(posedge CLK); #1;
    START = 1'b0;
    RESET = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge CLK); #3;
      checkIdleOutputs($sformatf("post_reset_c%0d", k));
    end

    // Full-rate transfer
    pushSeq(bytesA, 10, 1, 10, 0, 11);
    applyStimulus(WORD_A, 13, 0, -1, -1, 1'b0, -1, '0, 10, 8'h00);
    drainCheck("full_rate");

    // Backpressure on cycles 3..6
    pushSeq(bytesA, 10, 1, 2, 4, 15);
    applyStimulus(WORD_A, 17, 3, 6, -1, 1'b0, -1, '0, 14, 8'hEF);
    drainCheck("backpressure");

    // Extra START at cycle 4, reg_in flipped to all-ones at cycle 2
    pushSeq(bytesA, 10, 1, 10, 0, 11);
    applyStimulus(WORD_A, 13, 0, -1, 4, 1'b0, 2, {80{1'b1}}, 10, 8'h00);
    drainCheck("isolation");

    // Reset right after byte 5 is accepted
    pushSeq(bytesA, 6, 1, 10, 0, 0);
    applyStimulus(WORD_A, 6, 0, -1, -1, 1'b0, -1, '0, 10, 8'h00);
    @(posedge CLK); #3;
    RESET = 1'b0;
    #1;
    checkIdleOutputs("mid_reset");
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b1;
    drainCheck("mid_reset");

    pushSeq(bytesB, 10, 1, 10, 0, 11);
    applyStimulus(WORD_B, 13, 0, -1, -1, 1'b0, -1, '0, 10, 8'h00);
    drainCheck("after_reset");

    // START held through two words; second snapshot only once back in IDLE
    pushSeq(bytesA, 10, 1, 10, 0, 11);
    pushSeq(bytesB, 10, 13, 10, 0, 23);
    applyStimulus(WORD_A, 23, 0, -1, -1, 1'b1, 1, WORD_B, 0, 8'h00);
    drainCheck("back_to_back");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg80_byte_reader.md
Name:
reg80_byte_reader

Overview:
- Reader end of the 80-bit parallel state register: takes a snapshot of an 80-bit word and streams it out as 10 bytes.
- Byte transfer uses a valid/ready handshake, least-significant byte first, matching the byte-lane order of the register (bits [7:0] first, bits [79:72] last).
- Sits between the 80-bit register bank and any byte-wide consumer (UART, bus bridge, checker).

Parameters:
- NBYTES, 10, number of bytes per word.
- BYTE_W, 8, byte width; word width is NBYTES*BYTE_W (80).

Ports:
- CLK  input  1  system clock, rising-edge.
- RESET  input  1  asynchronous, active-low reset.
- START  input  1  request to snapshot reg_in and begin a transfer; honoured only in IDLE.
- reg_in  input  80  parallel word from the register bank.
- BUSY  output  1  high from the cycle after an accepted START until the transfer completes.
- byte_out  output  8  current byte.
- byte_valid  output  1  byte_out holds a valid byte.
- byte_ready  input  1  consumer accepts byte_out this cycle.
- LAST  output  1  high while byte_out holds byte NBYTES-1.
- DONE  output  1  one-cycle pulse after the final byte is accepted.

Behaviour:
- Reset (RESET=0, asynchronous): state=IDLE, byte index=0, snapshot=0, BUSY=0, byte_valid=0, byte_out=0x00, LAST=0, DONE=0. Reset mid-transfer aborts immediately. No further bytes are emitted, and DONE does not pulse.
- States: IDLE, SEND, FINISH.
- IDLE, START=1 at edge N:
  - snapshot <= reg_in; index <= 0; state <= SEND.
  - From cycle N+1: BUSY=1, byte_valid=1, byte_out=reg_in[7:0].
- SEND:
  - byte_out = snapshot[8*idx+7 : 8*idx]; LAST = (idx==NBYTES-1).
  - Transfer occurs on an edge where byte_valid=1 and byte_ready=1.
  - On transfer with idx<NBYTES-1: idx <= idx+1. The next byte is presented the following cycle. Throughput is one byte per cycle when byte_ready is held high.
  - On transfer with idx==NBYTES-1: state <= FINISH; byte_valid drops the next cycle.
  - When byte_valid=1 and byte_ready=0: byte_out, LAST, and idx hold stable. No byte is dropped or duplicated.
- FINISH: DONE=1, BUSY=0, byte_valid=0 for exactly one cycle, then state <= IDLE unconditionally.
- START is ignored in SEND and FINISH. It is not queued.
- Changes on reg_in after the snapshot edge have no effect on the current transfer.
- Minimum START-to-START spacing: NBYTES+2 cycles (snapshot, 10 bytes, FINISH).
- byte_ready while byte_valid=0 is ignored.
- Index counter: 4 bits, saturating range 0..NBYTES-1, never wraps.
- All outputs are registered. There are no combinational paths from byte_ready to the outputs.

Decomposition:
- Shared package holds:
  - NBYTES and BYTE_W constants.
  - WORD_W = NBYTES*BYTE_W.
  - The state encoding typedef (IDLE=2'd0, SEND=2'd1, FINISH=2'd2).
- Sub-module reg80_snapshot: an 80-bit load-enabled, async active-low reset holding register built from the team's existing 8-bit register cells. The reader owns only the FSM, the index counter, and byte selection.

Test Plan:
- Reset check:
  - Stimulus: assert RESET=0 with random inputs.
  - Required: all outputs 0; after release with START=0 for 5 cycles, outputs remain 0.
- Full-rate transfer:
  - Stimulus: reg_in=0x0123456789ABCDEF0011, START pulse at cycle 0, byte_ready=1.
  - Required: byte_out on cycles 1..10 = 11,00,EF,CD,AB,89,67,45,23,01; LAST only at cycle 10; DONE only at cycle 11; BUSY high on cycles 1..10.
- Backpressure:
  - Stimulus: same word, byte_ready low on cycles 3..6.
  - Required: byte_out holds 0xEF through the stall; the complete sequence is unchanged; DONE is delayed 4 cycles to cycle 15.
- Ignored START and snapshot isolation:
  - Stimulus: START asserted again at cycle 4, and reg_in changed to all-ones at cycle 2.
  - Required: the byte stream still matches the original snapshot; exactly one DONE pulse.
- Reset mid-transfer:
  - Stimulus: RESET=0 asynchronously after byte 5 is accepted.
  - Required: byte_valid, BUSY, and byte_out go to 0 immediately; no DONE pulse.
  - Follow-up: a new START after release streams from byte 0.
- Back-to-back words:
  - Stimulus: START held high continuously with two different words.
  - Required: the second snapshot is taken only in IDLE, at cycle 12; exactly 20 bytes total; two DONE pulses, at cycles 11 and 23.
